// File: rtl/dmem_access_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_access_ctrl
//
// Sits between the MEM pipeline stage and a word-wide data memory. Each
// accepted load or store is range- and alignment-checked. Legal requests read
// the addressed memory word. Stores then write back a merged word. Loads
// return the extracted, extended lane. Only one request is in flight at a time.
//
// Handshake: a request transfers on a rising clock edge where req_valid and
// req_ready are both 1. The requester keeps req_valid and all req_* fields
// stable until that edge. req_ready is only 1 in IDLE. resp_valid is a single
// cycle pulse with no back-pressure. resp_rdata and resp_error qualify it.
//
// Ports:
//   clock, reset          single clock, asynchronous active-high reset
//   req_valid/req_ready   request handshake
//   req_write             1 = store, 0 = load
//   req_addr              byte address
//   req_size              0 byte, 1 half, 2 word, 3 illegal
//   req_unsigned          zero-extend (1) or sign-extend (0) loads
//   req_wdata             right-justified store data
//   resp_valid            completion pulse
//   resp_rdata            extended load data, 0 for stores and errors
//   resp_error            request rejected
//   mem_address           word-aligned memory address
//   mem_read_write        1 = write memory word this cycle
//   mem_data_in           word written to memory
//   mem_access_size       always word (2)
//   mem_data_out          combinational memory read data
//   dbg_state             current FSM state (0 IDLE, 1 RD, 2 WR, 3 RESP)
// -----------------------------------------------------------------------------
module dmem_access_ctrl #(
    parameter logic [31:0] MEM_BASE  = 32'h01000000,
    parameter logic [31:0] MEM_BYTES = 32'h00100000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_address,
    output logic        mem_read_write,
    output logic [31:0] mem_data_in,
    output logic [1:0]  mem_access_size,
    input  logic [31:0] mem_data_out,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    // One past the last legal byte, kept at 33 bits so the window end never wraps.
    localparam logic [32:0] MEM_LIMIT = {1'b0, MEM_BASE} + {1'b0, MEM_BYTES};

    state_t      state;
    state_t      state_nxt;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        write_q;
    logic        unsigned_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic [31:0] word_q;

    logic        accept;
    logic [2:0]  req_bytes;
    logic [32:0] req_end;
    logic        req_err;
    logic [31:0] load_val;
    logic [31:0] merged;

    assign accept = req_valid && req_ready;

    // Acceptance-time legality check.
    always_comb begin
        req_bytes = 3'd4;
        case (req_size)
            2'd0:    req_bytes = 3'd1;
            2'd1:    req_bytes = 3'd2;
            default: req_bytes = 3'd4;
        endcase
        req_end = {1'b0, req_addr} + {30'b0, req_bytes};
        req_err = (req_size == 2'd3)
               || ((req_size == 2'd1) && req_addr[0])
               || ((req_size == 2'd2) && (req_addr[1:0] != 2'b00))
               || (req_addr < MEM_BASE)
               || (req_end > MEM_LIMIT);
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = req_err ? S_RESP : S_RD;
                end
            end
            S_RD:    state_nxt = write_q ? S_WR : S_RESP;
            S_WR:    state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Request capture, memory address and read-word register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q      <= '0;
            size_q      <= '0;
            write_q     <= 1'b0;
            unsigned_q  <= 1'b0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
            word_q      <= '0;
            mem_address <= '0;
        end else begin
            if (accept) begin
                addr_q     <= req_addr;
                size_q     <= req_size;
                write_q    <= req_write;
                unsigned_q <= req_unsigned;
                wdata_q    <= req_wdata;
                err_q      <= req_err;
                // Rejected requests leave the memory address untouched.
                if (!req_err) begin
                    mem_address <= {req_addr[31:2], 2'b00};
                end
            end
            if (state == S_RD) begin
                word_q <= mem_data_out;
            end
        end
    end

    // Load lane extraction and extension.
    always_comb begin
        load_val = word_q;
        case (size_q)
            2'd0: begin
                load_val[7:0]  = word_q[{addr_q[1:0], 3'b000} +: 8];
                load_val[31:8] = {24{~unsigned_q & load_val[7]}};
            end
            2'd1: begin
                load_val[15:0]  = word_q[{addr_q[1], 4'b0000} +: 16];
                load_val[31:16] = {16{~unsigned_q & load_val[15]}};
            end
            default: load_val = word_q;
        endcase
    end

    // Store merge: new lanes over the word read in RD.
    always_comb begin
        merged = word_q;
        case (size_q)
            2'd0:    merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            2'd1:    merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    // Outputs.
    always_comb begin
        req_ready       = (state == S_IDLE) && !reset;
        resp_valid      = (state == S_RESP);
        resp_error      = (state == S_RESP) && err_q;
        resp_rdata      = ((state == S_RESP) && !err_q && !write_q) ? load_val : 32'h0;
        mem_read_write  = (state == S_WR);
        mem_data_in     = (state == S_WR) ? merged : 32'h0;
        mem_access_size = 2'd2;
        dbg_state       = state;
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_access_ctrl
//
// Directed bench for dmem_access_ctrl. A word memory model answers the DUT's
// reads. At acceptance the driver predicts each request's response and memory
// traffic from the access rules and queues them. A per-cycle compare process
// checks every output against those queues.
// -----------------------------------------------------------------------------
module tb_dmem_access_ctrl;

    localparam logic [31:0] BASE  = 32'h01000000;
    localparam logic [31:0] BYTES = 32'h00100000;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [1:0]  req_size = '0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_address;
    logic        mem_read_write;
    logic [31:0] mem_data_in;
    logic [1:0]  mem_access_size;
    logic [31:0] mem_data_out;
    logic [1:0]  dbg_state;

    dmem_access_ctrl #(.MEM_BASE(BASE), .MEM_BYTES(BYTES)) dut (
        .clock           (clock),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_addr        (req_addr),
        .req_size        (req_size),
        .req_unsigned    (req_unsigned),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_error      (resp_error),
        .mem_address     (mem_address),
        .mem_read_write  (mem_read_write),
        .mem_data_in     (mem_data_in),
        .mem_access_size (mem_access_size),
        .mem_data_out    (mem_data_out),
        .dbg_state       (dbg_state)
    );

    // ---------------- data memory (64 words, aliased on addr[7:2]) ----------------
    function automatic logic [31:0] init_word(int i);
        if (i == 4) return 32'h8899AABB;
        return 32'h10000000 + i * 32'h01010101;
    endfunction

    logic [31:0] env_mem [0:63];
    logic        mem_init_done = 1'b0;
    assign mem_data_out = env_mem[mem_address[7:2]];

    always @(posedge clock) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 64; i++) env_mem[i] <= init_word(i);
            mem_init_done <= 1'b1;
        end else if (mem_read_write) begin
            env_mem[mem_address[7:2]] <= mem_data_in;
        end
    end

    // ---------------- checking helpers ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%08h required 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: expected event did not occur (cycle %0d)", name, cyc);
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] mem_wr [int];   // model memory: words written so far

    function automatic logic [31:0] model_mem(int idx);
        if (mem_wr.exists(idx)) return mem_wr[idx];
        return init_word(idx);
    endfunction

    function automatic int nbytes_of(logic [1:0] s);
        if (s == 2'd0) return 1;
        if (s == 2'd1) return 2;
        return 4;
    endfunction

    function automatic bit model_err(logic [31:0] a, logic [1:0] s);
        longint unsigned la, lim;
        int nb;
        if (s == 2'd3) return 1'b1;
        nb  = nbytes_of(s);
        la  = a;
        lim = longint'(BASE) + longint'(BYTES);
        if ((la % nb) != 0) return 1'b1;
        if (la < BASE) return 1'b1;
        if (la + nb > lim) return 1'b1;
        return 1'b0;
    endfunction

    // Byte offset of the first lane touched by an aligned access.
    function automatic int lane_off(logic [31:0] a, logic [1:0] s);
        int lane;
        lane = int'(a[1:0]);
        return lane - (lane % nbytes_of(s));
    endfunction

    function automatic logic [31:0] model_load(logic [31:0] word, logic [31:0] a,
                                               logic [1:0] s, logic u);
        longint unsigned v, mask, one;
        int nb;
        one  = 1;
        nb   = nbytes_of(s);
        mask = (one << (8 * nb)) - 1;
        v    = (longint'(word) >> (8 * lane_off(a, s))) & mask;
        if (!u && nb < 4 && ((v >> (8 * nb - 1)) & one) == one) v = v | ~mask;
        return v[31:0];
    endfunction

    function automatic logic [31:0] model_store(logic [31:0] word, logic [31:0] a,
                                                logic [1:0] s, logic [31:0] wd);
        longint unsigned mask, one, r;
        int nb, off;
        one  = 1;
        nb   = nbytes_of(s);
        off  = lane_off(a, s);
        mask = ((one << (8 * nb)) - 1) << (8 * off);
        r    = (longint'(word) & ~mask) | ((longint'(wd) << (8 * off)) & mask);
        return r[31:0];
    endfunction

    // ---------------- expectation queues ----------------
    int          resp_acc[$];    // accept cycle of outstanding request
    int          resp_cyc[$];    // cycle the response pulse must appear
    logic [31:0] exp_q[$];       // expected resp_rdata
    logic [31:0] exp_err_q[$];   // expected resp_error

    int          acc_cyc[$];     // cycle of an expected RD or WR access
    logic [31:0] acc_wr[$];
    logic [31:0] acc_addr[$];
    logic [31:0] acc_data[$];

    logic        pend = 1'b0;
    int          pend_idx = 0;
    logic [31:0] pend_data = '0;

    // ---------------- driver ----------------
    // exp_val: load result for loads, written memory word for stores.
    task automatic issue(string tag, logic w, logic [31:0] a, logic [1:0] s, logic u,
                         logic [31:0] wd, logic [31:0] exp_val, logic exp_e);
        int n, acc, idx;
        bit e;
        logic [31:0] word, val;
        req_write    = w;
        req_addr     = a;
        req_size     = s;
        req_unsigned = u;
        req_wdata    = wd;
        req_valid    = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (!req_ready) begin
            fail_now({tag, "_accept"});
        end else begin
            acc  = cyc + 1;
            e    = model_err(a, s);
            idx  = int'(a[7:2]);
            word = model_mem(idx);
            val  = e ? 32'h0 : (w ? model_store(word, a, s, wd) : model_load(word, a, s, u));
            chk({tag, "_model_val"}, val, exp_val);
            chk({tag, "_model_err"}, {31'b0, e}, {31'b0, exp_e});
            resp_acc.push_back(acc);
            resp_cyc.push_back(acc + (e ? 0 : (w ? 2 : 1)));
            exp_q.push_back((e || w) ? 32'h0 : val);
            exp_err_q.push_back({31'b0, e});
            if (!e) begin
                acc_cyc.push_back(acc);
                acc_wr.push_back(32'h0);
                acc_addr.push_back({a[31:2], 2'b00});
                acc_data.push_back(32'h0);
                if (w) begin
                    acc_cyc.push_back(acc + 1);
                    acc_wr.push_back(32'h1);
                    acc_addr.push_back({a[31:2], 2'b00});
                    acc_data.push_back(val);
                end
            end
        end
        @(negedge clock);
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        logic exp_ready;
        #1;
        if (reset) begin
            resp_acc.delete(); resp_cyc.delete(); exp_q.delete(); exp_err_q.delete();
            acc_cyc.delete(); acc_wr.delete(); acc_addr.delete(); acc_data.delete();
            pend = 1'b0;
        end else begin
            // A write that completed last cycle without reset lands in the model memory.
            if (pend) begin
                mem_wr[pend_idx] = pend_data;
                pend = 1'b0;
            end
            exp_ready = !(resp_acc.size() > 0 && resp_acc[0] <= cyc);
            chk("req_ready", {31'b0, req_ready}, {31'b0, exp_ready});

            while (resp_cyc.size() > 0 && resp_cyc[0] < cyc) begin
                fail_now("resp_missing");
                void'(resp_acc.pop_front()); void'(resp_cyc.pop_front());
                void'(exp_q.pop_front()); void'(exp_err_q.pop_front());
            end
            if (resp_cyc.size() > 0 && resp_cyc[0] == cyc) begin
                chk("resp_valid", {31'b0, resp_valid}, 32'h1);
                chk("resp_rdata", resp_rdata, exp_q[0]);
                chk("resp_error", {31'b0, resp_error}, exp_err_q[0]);
                void'(resp_acc.pop_front()); void'(resp_cyc.pop_front());
                void'(exp_q.pop_front()); void'(exp_err_q.pop_front());
            end else begin
                chk("resp_valid_idle", {31'b0, resp_valid}, 32'h0);
                chk("resp_rdata_idle", resp_rdata, 32'h0);
                chk("resp_error_idle", {31'b0, resp_error}, 32'h0);
            end

            while (acc_cyc.size() > 0 && acc_cyc[0] < cyc) begin
                fail_now("mem_access_missing");
                void'(acc_cyc.pop_front()); void'(acc_wr.pop_front());
                void'(acc_addr.pop_front()); void'(acc_data.pop_front());
            end
            if (acc_cyc.size() > 0 && acc_cyc[0] == cyc) begin
                chk("mem_read_write", {31'b0, mem_read_write}, acc_wr[0]);
                chk("mem_address", mem_address, acc_addr[0]);
                if (acc_wr[0] == 32'h1) begin
                    chk("mem_data_in", mem_data_in, acc_data[0]);
                    pend      = 1'b1;
                    pend_idx  = int'(acc_addr[0][7:2]);
                    pend_data = acc_data[0];
                end
                void'(acc_cyc.pop_front()); void'(acc_wr.pop_front());
                void'(acc_addr.pop_front()); void'(acc_data.pop_front());
            end else begin
                chk("mem_read_write_idle", {31'b0, mem_read_write}, 32'h0);
                chk("mem_data_in_idle", mem_data_in, 32'h0);
            end
            chk("mem_access_size", {30'b0, mem_access_size}, 32'h2);
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int bad;

        // Reset state.
        #1;
        chk("rst_req_ready", {31'b0, req_ready}, 32'h0);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_mem_rw", {31'b0, mem_read_write}, 32'h0);
        chk("rst_mem_address", mem_address, 32'h0);
        chk("rst_mem_data_in", mem_data_in, 32'h0);
        chk("rst_state", {30'b0, dbg_state}, 32'h0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Requests back to back with req_valid held high throughout.
        //     tag     w     addr          sz    u     wdata         expected      err
        issue("ld_w",  1'b0, 32'h01000010, 2'd2, 1'b0, 32'h0,        32'h8899AABB, 1'b0);
        issue("ld_bs", 1'b0, 32'h01000013, 2'd0, 1'b0, 32'h0,        32'hFFFFFF88, 1'b0);
        issue("ld_hu", 1'b0, 32'h01000010, 2'd1, 1'b1, 32'h0,        32'h0000AABB, 1'b0);
        issue("st_b",  1'b1, 32'h01000011, 2'd0, 1'b0, 32'h0000005A, 32'h88995ABB, 1'b0);
        issue("ld_w2", 1'b0, 32'h01000010, 2'd2, 1'b1, 32'h0,        32'h88995ABB, 1'b0);
        issue("ld_hs", 1'b0, 32'h01000012, 2'd1, 1'b0, 32'h0,        32'hFFFF8899, 1'b0);
        issue("ld_bu", 1'b0, 32'h01000011, 2'd0, 1'b1, 32'h0,        32'h0000005A, 1'b0);
        issue("e_half",1'b0, 32'h01000001, 2'd1, 1'b0, 32'h0,        32'h0,        1'b1);
        issue("e_low", 1'b0, 32'h00FFFFFC, 2'd2, 1'b0, 32'h0,        32'h0,        1'b1);
        issue("e_sz3", 1'b0, 32'h01000010, 2'd3, 1'b0, 32'h0,        32'h0,        1'b1);
        issue("st_top",1'b1, 32'h010FFFFC, 2'd2, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
        issue("ld_top",1'b0, 32'h010FFFFC, 2'd2, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0);
        issue("st_hi", 1'b1, 32'h010FFFFE, 2'd1, 1'b0, 32'h1234CAFE, 32'hCAFEBEEF, 1'b0);
        issue("e_end", 1'b1, 32'h01100000, 2'd2, 1'b0, 32'h11111111, 32'h0,        1'b1);
        issue("ld_bt", 1'b0, 32'h010FFFFF, 2'd0, 1'b0, 32'h0,        32'hFFFFFFCA, 1'b0);
        issue("st_h",  1'b1, 32'h01000010, 2'd1, 1'b0, 32'hFFFF7766, 32'h88997766, 1'b0);
        issue("e_mis", 1'b0, 32'h01000013, 2'd2, 1'b0, 32'h0,        32'h0,        1'b1);
        issue("e_wrap",1'b0, 32'hFFFFFFFC, 2'd2, 1'b0, 32'h0,        32'h0,        1'b1);
        issue("ld_hs2",1'b0, 32'h01000010, 2'd1, 1'b0, 32'h0,        32'h00007766, 1'b0);
        issue("st_b0", 1'b1, 32'h01000010, 2'd0, 1'b0, 32'h000000F0, 32'h889977F0, 1'b0);
        issue("ld_b0", 1'b0, 32'h01000010, 2'd0, 1'b0, 32'h0,        32'hFFFFFFF0, 1'b0);
        req_valid = 1'b0;
        repeat (5) @(negedge clock);

        // Reset during WR aborts the store.
        issue("st_abt",1'b1, 32'h01000021, 2'd0, 1'b0, 32'h000000A5, 32'h1808A508, 1'b0);
        req_valid = 1'b0;
        @(negedge clock);                 // now in WR
        #3;
        reset = 1'b1;
        #1;
        chk("abt_mem_rw", {31'b0, mem_read_write}, 32'h0);
        chk("abt_resp_valid", {31'b0, resp_valid}, 32'h0);
        chk("abt_req_ready", {31'b0, req_ready}, 32'h0);
        chk("abt_mem_address", mem_address, 32'h0);
        chk("abt_mem_data_in", mem_data_in, 32'h0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        #2;
        chk("abt_ready_after", {31'b0, req_ready}, 32'h1);
        chk("abt_no_resp", {31'b0, resp_valid}, 32'h0);
        @(negedge clock);
        issue("ld_abt",1'b0, 32'h01000020, 2'd2, 1'b0, 32'h0,        32'h18080808, 1'b0);
        req_valid = 1'b0;
        repeat (6) @(negedge clock);

        // Everything predicted has been seen, and the memory image matches the model.
        chk("resp_drain", resp_cyc.size(), 32'h0);
        chk("access_drain", acc_cyc.size(), 32'h0);
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            if (env_mem[i] !== model_mem(i)) bad++;
        end
        chk("mem_image", bad, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
